// File: rtl/wfg_wb_seq_master_if.sv
// ---------------------------------------------------------------------------
// wfg_wb_seq_master_if
//
// Wishbone bus bundle between the wfg script sequencer (initiator) and the
// wfg Wishbone responder.  Signal names keep the initiator's point of view
// (_o = driven by the initiator, _i = driven by the responder).
//
// Parameters
//   BUSW        Wishbone address/data width
//
// Signals
//   wbm_cyc_o   cycle valid
//   wbm_stb_o   strobe
//   wbm_we_o    1 = write, 0 = read
//   wbm_adr_o   byte address (BUSW bits)
//   wbm_dat_o   write data   (BUSW bits)
//   wbm_sel_o   byte lanes, always all-ones
//   wbm_ack_i   responder acknowledge
//   wbm_dat_i   responder read data (BUSW bits)
//
// Modports
//   master      used by wfg_wb_seq_master
//   slave       used by the responder
// ---------------------------------------------------------------------------
interface wfg_wb_seq_master_if #(
    parameter int BUSW = 32
);
    logic            wbm_cyc_o;
    logic            wbm_stb_o;
    logic            wbm_we_o;
    logic [BUSW-1:0] wbm_adr_o;
    logic [BUSW-1:0] wbm_dat_o;
    logic [3:0]      wbm_sel_o;
    logic            wbm_ack_i;
    logic [BUSW-1:0] wbm_dat_i;

    modport master (
        output wbm_cyc_o,
        output wbm_stb_o,
        output wbm_we_o,
        output wbm_adr_o,
        output wbm_dat_o,
        output wbm_sel_o,
        input  wbm_ack_i,
        input  wbm_dat_i
    );

    modport slave (
        input  wbm_cyc_o,
        input  wbm_stb_o,
        input  wbm_we_o,
        input  wbm_adr_o,
        input  wbm_dat_o,
        input  wbm_sel_o,
        output wbm_ack_i,
        output wbm_dat_i
    );
endinterface

// File: rtl/wfg_wb_seq_master.sv
// ---------------------------------------------------------------------------
// wfg_wb_seq_master
//
// Script-driven Wishbone initiator for the waveform generator.  After a start
// pulse it fetches command words from a single-port, read-only script SRAM
// and turns them into Wishbone write/read cycles on the wfg register map, so
// the generator can be configured without a CPU.
//
// Script format (one 32-bit header word per command):
//   [31:30] opcode   00 END, 01 WRITE, 10 READ, 11 WAIT
//   [23:0]  arg      WRITE/READ: arg[7:0] = register address
//                    WAIT:       arg      = cycle count (0 is illegal)
//   WRITE is followed by one data word.
//
// Optional feature (compile-time macro WFG_WB_SEQ_TIMEOUT_EN):
//   defined     a bus access that sees no ack within TIMEOUT strobe cycles is
//               abandoned, error_o is set and the script stops.
//   undefined   the bus access waits for ack indefinitely.
//
// Parameters
//   BUSW        Wishbone address/data width
//   MEM_AW      script memory word-address width
//   TIMEOUT     strobe cycles allowed before giving up (timeout build only)
//
// Ports
//   wb_clk_i    clock, everything on the rising edge
//   wb_rst_ni   synchronous active-low reset
//   start_i     start pulse, ignored while busy
//   base_addr_i first script word, sampled on an accepted start
//   busy_o      script executing
//   done_o      sticky, END reached
//   error_o     sticky, illegal opcode or bus timeout
//   cmd_count_o commands completed since the last start
//   rd_data_o   data returned by the last completed READ
//   csb_o       script memory chip select (active low)
//   addr_o      script memory word address
//   dout_i      script memory read data, valid the cycle after csb_o=0
//   wbm         Wishbone initiator side (wfg_wb_seq_master_if.master)
// ---------------------------------------------------------------------------
module wfg_wb_seq_master #(
    parameter int BUSW    = 32,
    parameter int MEM_AW  = 10,
    parameter int TIMEOUT = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,

    input  logic                 start_i,
    input  logic [MEM_AW-1:0]    base_addr_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [MEM_AW-1:0]    cmd_count_o,
    output logic [BUSW-1:0]      rd_data_o,

    output logic                 csb_o,
    output logic [MEM_AW-1:0]    addr_o,
    input  logic [31:0]          dout_i,

    wfg_wb_seq_master_if.master  wbm
);

    // -----------------------------------------------------------------------
    // Opcodes and FSM states
    // -----------------------------------------------------------------------
    localparam logic [1:0] OP_END   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WAIT  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR_REQ = 3'd1,
        S_HDR_CAP = 3'd2,
        S_DAT_REQ = 3'd3,
        S_DAT_CAP = 3'd4,
        S_WB      = 3'd5,
        S_DELAY   = 3'd6,
        S_STOP    = 3'd7
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [MEM_AW-1:0]   ptr_q,       ptr_d;       // next script word
    logic [1:0]          op_q,        op_d;        // opcode of current command
    logic [23:0]         arg_q,       arg_d;       // argument of current command
    logic [BUSW-1:0]     wdat_q,      wdat_d;      // WRITE data word
    logic [23:0]         delay_q,     delay_d;     // WAIT cycles remaining
    logic                done_q,      done_d;
    logic                error_q,     error_d;
    logic [MEM_AW-1:0]   cmd_count_q, cmd_count_d;
    logic [BUSW-1:0]     rd_data_q,   rd_data_d;

`ifdef WFG_WB_SEQ_TIMEOUT_EN
    // Counts strobe cycles of the current access; wraps after TIMEOUT-1.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0]     to_q,        to_d;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_d        = op_q;
        arg_d       = arg_q;
        wdat_d      = wdat_q;
        delay_d     = delay_q;
        done_d      = done_q;
        error_d     = error_q;
        cmd_count_d = cmd_count_q;
        rd_data_d   = rd_data_q;
`ifdef WFG_WB_SEQ_TIMEOUT_EN
        to_d        = to_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    cmd_count_d = '0;
                    ptr_d       = base_addr_i;
                    state_d     = S_HDR_REQ;
                end
            end

            // Memory read request; the word appears on dout_i next cycle.
            S_HDR_REQ: state_d = S_HDR_CAP;

            S_HDR_CAP: begin
                op_d  = dout_i[31:30];
                arg_d = dout_i[23:0];
                ptr_d = ptr_q + MEM_AW'(1);   // wraps modulo 2^MEM_AW
`ifdef WFG_WB_SEQ_TIMEOUT_EN
                to_d  = '0;
`endif
                unique case (dout_i[31:30])
                    OP_END: begin
                        done_d  = 1'b1;
                        state_d = S_STOP;
                    end
                    OP_WRITE: state_d = S_DAT_REQ;
                    OP_READ:  state_d = S_WB;
                    OP_WAIT: begin
                        if (dout_i[23:0] == 24'd0) begin
                            // A zero-length wait is treated as a corrupt script.
                            error_d = 1'b1;
                            state_d = S_STOP;
                        end else begin
                            delay_d = dout_i[23:0];
                            state_d = S_DELAY;
                        end
                    end
                    default: state_d = S_STOP;
                endcase
            end

            S_DAT_REQ: state_d = S_DAT_CAP;

            S_DAT_CAP: begin
                wdat_d  = BUSW'(dout_i);
                ptr_d   = ptr_q + MEM_AW'(1);
                state_d = S_WB;
            end

            // cyc/stb are decoded from this state, so leaving it on the ack
            // edge drops them on that same edge and guarantees at least one
            // idle cycle (the next header fetch) between accesses.
            S_WB: begin
                if (wbm.wbm_ack_i) begin
                    if (op_q == OP_READ) begin
                        rd_data_d = wbm.wbm_dat_i;
                    end
                    cmd_count_d = cmd_count_q + MEM_AW'(1);
                    state_d     = S_HDR_REQ;
                end
`ifdef WFG_WB_SEQ_TIMEOUT_EN
                else if (to_q == TO_LAST) begin
                    // Abandoned access is not counted as a completed command.
                    error_d = 1'b1;
                    state_d = S_STOP;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
`endif
            end

            // Stays here exactly arg cycles (arg >= 1 guaranteed above).
            S_DELAY: begin
                if (delay_q == 24'd1) begin
                    cmd_count_d = cmd_count_q + MEM_AW'(1);
                    state_d     = S_HDR_REQ;
                end else begin
                    delay_d = delay_q - 24'd1;
                end
            end

            // One cycle with busy low before IDLE; a start arriving now is
            // deliberately dropped.
            S_STOP: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            op_q        <= OP_END;
            arg_q       <= '0;
            wdat_q      <= '0;
            delay_q     <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cmd_count_q <= '0;
            rd_data_q   <= '0;
`ifdef WFG_WB_SEQ_TIMEOUT_EN
            to_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_q        <= op_d;
            arg_q       <= arg_d;
            wdat_q      <= wdat_d;
            delay_q     <= delay_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cmd_count_q <= cmd_count_d;
            rd_data_q   <= rd_data_d;
`ifdef WFG_WB_SEQ_TIMEOUT_EN
            to_q        <= to_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: decoded from the registered state so reset clears them on the
    // edge it is sampled.
    // -----------------------------------------------------------------------
    assign busy_o      = (state_q != S_IDLE) && (state_q != S_STOP);
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign cmd_count_o = cmd_count_q;
    assign rd_data_o   = rd_data_q;

    assign csb_o       = !((state_q == S_HDR_REQ) || (state_q == S_DAT_REQ));
    assign addr_o      = ptr_q;

    assign wbm.wbm_cyc_o = (state_q == S_WB);
    assign wbm.wbm_stb_o = (state_q == S_WB);
    assign wbm.wbm_we_o  = (state_q == S_WB) && (op_q == OP_WRITE);
    assign wbm.wbm_adr_o = BUSW'(arg_q[7:0]);
    assign wbm.wbm_dat_o = wdat_q;
    assign wbm.wbm_sel_o = 4'b1111;

endmodule

// File: doc/wfg_wb_seq_master.md
# wfg_wb_seq_master

Wishbone initiator that configures the waveform generator without an external CPU: it fetches a command script from a single-port, read-only SRAM port and issues the corresponding Wishbone write/read cycles to the wfg register map (core, interconnect, stimuli, drivers). It sits in front of the wfg Wishbone responder and shares that bus's clock and address map (0x10–0x6F).

## Interface
- BUSW, 32, Wishbone address/data width
- MEM_AW, 10, script memory word-address width
- TIMEOUT, 255, max cycles waiting for ack (used only with timeout feature)

- wb_clk_i  in  1  clock, all logic rising-edge
- wb_rst_ni  in  1  reset, synchronous, active-low
- start_i  in  1  pulse: begin script at base_addr_i (ignored while busy_o=1)
- base_addr_i  in  MEM_AW  first script word address, sampled on accepted start
- busy_o  out  1  script executing
- done_o  out  1  sticky: END reached; cleared on next accepted start
- error_o  out  1  sticky: illegal opcode or timeout; cleared on next accepted start
- cmd_count_o  out  MEM_AW  commands completed since start
- rd_data_o  out  BUSW  data of last completed READ
- csb_o  out  1  memory chip select, active-low
- addr_o  out  MEM_AW  memory word address
- dout_i  in  32  memory read data, valid one cycle after csb_o=0
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls
- wbm_adr_o, wbm_dat_o  out  BUSW  address, write data
- wbm_sel_o  out  4  always 4'b1111
- wbm_ack_i  in  1  responder acknowledge
- wbm_dat_i  in  BUSW  responder read data

## Operation
- Header word: [31:30] opcode, [23:0] arg. 00 END; 01 WRITE (arg[7:0]=adr, next word=data); 10 READ (arg[7:0]=adr); 11 WAIT (arg=cycle count) — 11 with arg=0 is illegal.
- wbm_adr_o = {24'h0, arg[7:0]}; pointer increments by 1 per fetched word, wraps modulo 2^MEM_AW.
- FSM states: IDLE, HDR_REQ, HDR_CAP, DAT_REQ, DAT_CAP, WB, DELAY, STOP.
- IDLE: accepted start -> clear done/error/cmd_count, ptr=base_addr_i, -> HDR_REQ.
- HDR_REQ: csb_o=0, addr_o=ptr, -> HDR_CAP. HDR_CAP: latch dout_i, ptr++; END -> STOP(done); WRITE -> DAT_REQ; READ -> WB; WAIT -> DELAY; illegal -> STOP(error).
- DAT_REQ/DAT_CAP: same fetch, latched word drives wbm_dat_o, -> WB.
- WB: cyc=stb=1, we=1 for WRITE; hold all until ack; on ack drop cyc/stb same edge, latch wbm_dat_i into rd_data_o for READ, cmd_count++, -> HDR_REQ.
- DELAY: count arg cycles, then cmd_count++, -> HDR_REQ.
- STOP: busy_o=0, -> IDLE.
- cmd_count_o counts END? No — END and illegal are not counted.
- Reset values: all outputs 0 except csb_o=1, wbm_sel_o=4'b1111. Reset mid-cycle drops cyc/stb on the next edge; no partial state retained.
- start_i during busy_o=1 is ignored; start_i on the same edge STOP returns to IDLE is ignored.

## Timing
- Fetch: csb_o low exactly one cycle per word; dout_i sampled the following edge.
- wbm_stb_o asserts the cycle after the last fetch capture; an ack in the first stb cycle completes a single-cycle bus access.
- WRITE with zero-wait ack: 2 (header) + 2 (data) + 1 (bus) = 5 cycles; READ: 3; WAIT n: 2 + n.
- busy_o rises the edge after accepted start_i; falls the edge done_o/error_o rises.
- Back-to-back: next HDR_REQ the cycle after ack; cyc_o deasserts for at least one cycle between accesses.

## Configuration
- WFG_WB_SEQ_TIMEOUT_EN defined: WB state counts stb cycles; if TIMEOUT cycles elapse without ack, drop cyc/stb, set error_o, -> STOP; command not counted.
- Not defined: WB waits for ack indefinitely; error_o set only by illegal opcode.

## Test plan
- Script @0: WRITE 0x24/0x0000_1234, END; ack 1 cycle after stb -> one write to adr 0x24 data 0x1234, done_o=1, cmd_count_o=1, error_o=0.
- Script @0x3FE: WRITE 0x10/0x1, READ 0x10, END with responder returning 0xCAFE -> pointer wraps to 0x000, rd_data_o=0xCAFE, cmd_count_o=2.
- WAIT 5 between two WRITEs -> stb of second write exactly 2+5+4 cycles after first ack edge.
- Header 0xC000_0000 -> error_o=1, done_o=0, no Wishbone cycle issued.
- Macro on, TIMEOUT=8, responder never acks -> stb high 8 cycles, then cyc/stb low, error_o=1; macro off -> stb held for 1000 cycles.
- Assert wb_rst_ni=0 mid-WB cycle -> next edge cyc/stb=0, csb_o=1, busy_o=0; new start_i runs script normally.
